// File: rtl/amstrad_mmu_pkg.sv
// Shared constants for the CPC/CPC-Plus memory manager: I/O port codes,
// Gate-Array function codes, lower-ROM location encodings and the ASIC unlock table.
package amstrad_mmu_pkg;

  localparam logic [7:0] PORT_GA   = 8'h7F;
  localparam logic [7:0] PORT_ROM  = 8'hDF;
  localparam logic [7:0] PORT_CRTC = 8'hBC;

  localparam logic [1:0] FN_MMR  = 2'b11;
  localparam logic [2:0] FN_RMR  = 3'b100;
  localparam logic [2:0] FN_RMR2 = 3'b101;

  typedef enum logic [1:0] {
    LOC_Q0   = 2'b00,
    LOC_Q1   = 2'b01,
    LOC_Q2   = 2'b10,
    LOC_ASIC = 2'b11
  } lo_loc_e;

  localparam int PAGE_BASIC  = 1;
  localparam int PAGE_AMSDOS = 3;

  localparam logic [4:0] UNLOCK_LAST = 5'd16;

  function automatic logic [7:0] unlock_byte(input logic [4:0] idx);
    logic [7:0] b;
    case (idx)
      5'd0:    b = 8'hFF;
      5'd1:    b = 8'h00;
      5'd2:    b = 8'hFF;
      5'd3:    b = 8'h77;
      5'd4:    b = 8'hB3;
      5'd5:    b = 8'h51;
      5'd6:    b = 8'hA8;
      5'd7:    b = 8'hD4;
      5'd8:    b = 8'h62;
      5'd9:    b = 8'h39;
      5'd10:   b = 8'h9C;
      5'd11:   b = 8'h46;
      5'd12:   b = 8'h2B;
      5'd13:   b = 8'h15;
      5'd14:   b = 8'h8A;
      5'd15:   b = 8'hCD;
      5'd16:   b = 8'hEE;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/amstrad_mmu_plus_asic_unlock.sv
// ASIC unlock sequence tracker: walks the 17-byte table on CRTC-select writes;
// the final byte decides whether the ASIC ends up unlocked or re-locked.
module asic_unlock (
  input  logic       CLK,
  input  logic       reset,
  input  logic       wr_stb,
  input  logic [7:0] D,
  output logic       unlocked
);
  import amstrad_mmu_pkg::*;

  logic [4:0] idx_q, idx_d;
  logic       unlocked_q, unlocked_d;

  always_ff @(posedge CLK) begin
    if (reset) begin
      idx_q      <= 5'd0;
      unlocked_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      unlocked_q <= unlocked_d;
    end
  end

  always_comb begin
    idx_d      = idx_q;
    unlocked_d = unlocked_q;
    if (wr_stb) begin
      if (idx_q == UNLOCK_LAST) begin
        unlocked_d = (D == unlock_byte(UNLOCK_LAST));
        idx_d      = 5'd0;
      end else if (D == unlock_byte(idx_q)) begin
        idx_d = idx_q + 5'd1;
      end else begin
        // A stray FF doubles as the first byte of a fresh attempt.
        idx_d = (D == 8'hFF) ? 5'd1 : 5'd0;
      end
    end
  end

  assign unlocked = unlocked_q;

endmodule

// File: rtl/amstrad_mmu_plus.sv
// CPC/CPC-Plus memory manager: decodes GA/ROM-select/CRTC writes and registers
// the SDRAM address {cart, page, A[13:0]} for every CPU access.
module amstrad_mmu_plus #(
  parameter int  EXP_BITS  = 3,
  parameter int  CART_BITS = 5,
  localparam int AW = 15 + ((EXP_BITS + 3 > CART_BITS) ? EXP_BITS + 3 : CART_BITS)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          ram64k,
  input  logic          romen_n,
  input  logic          io_WR,
  input  logic [15:0]   A,
  input  logic [7:0]    D,
  output logic [AW-1:0] ram_A,
  output logic          asic_sel,
  output logic [1:0]    mode,
  output logic          int_reset,
  output logic          rmr2_now,
  output logic          unlocked
);
  import amstrad_mmu_pkg::*;

  localparam int PW = AW - 15;

  // io_WR is a level; a write is taken once, on the first cycle it is seen high.
  logic io_wr_q, wr_stb;
  assign wr_stb = io_WR & ~io_wr_q;

  logic [2:0]          map_q, map_d;
  logic [EXP_BITS-1:0] bank_q, bank_d;
  logic [1:0]          mode_q, mode_d;
  logic                lo_dis_q, lo_dis_d, hi_dis_q, hi_dis_d;
  lo_loc_e             lo_loc_q, lo_loc_d;
  logic [2:0]          lo_page_q, lo_page_d;
  logic                rmr2_seen_q, rmr2_seen_d;
  logic [7:0]          rom_bank_q, rom_bank_d;
  logic                int_reset_q, int_reset_d, rmr2_now_q, rmr2_now_d;
  logic [AW-1:0]       ram_a_q, ram_a_d;
  logic                asic_q, asic_d;

  asic_unlock u_unlock (
    .CLK      (CLK),
    .reset    (reset),
    .wr_stb   (wr_stb && (A[15:8] == PORT_CRTC)),
    .D        (D),
    .unlocked (unlocked)
  );

  always_comb begin
    map_d       = map_q;
    bank_d      = bank_q;
    mode_d      = mode_q;
    lo_dis_d    = lo_dis_q;
    hi_dis_d    = hi_dis_q;
    lo_loc_d    = lo_loc_q;
    lo_page_d   = lo_page_q;
    rmr2_seen_d = rmr2_seen_q;
    rom_bank_d  = rom_bank_q;
    int_reset_d = 1'b0;
    rmr2_now_d  = 1'b0;
    if (wr_stb && (A[15:8] == PORT_GA)) begin
      if (D[7:6] == FN_MMR) begin
        if (!ram64k) begin
          map_d  = D[2:0];
          bank_d = EXP_BITS'({~A[10:8], D[5:3]});
        end
      end else if (D[7:5] == FN_RMR) begin
        mode_d      = D[1:0];
        lo_dis_d    = D[2];
        hi_dis_d    = D[3];
        int_reset_d = D[4];
      end else if ((D[7:5] == FN_RMR2) && unlocked) begin
        lo_loc_d    = lo_loc_e'(D[4:3]);
        lo_page_d   = D[2:0];
        rmr2_seen_d = 1'b1;
        rmr2_now_d  = 1'b1;
      end
    end
    if (wr_stb && (A[15:8] == PORT_ROM)) rom_bank_d = D;
  end

  logic [1:0]           q, lo_slot, slot, base_page;
  logic                 use_ext;
  logic [EXP_BITS:0]    bank_p1;
  logic [2:0]           lo_rom_page;
  logic [CART_BITS-1:0] hi_page;

  always_comb begin
    q         = A[15:14];
    slot      = q;
    base_page = q;
    use_ext   = 1'b0;
    // 6128 banking: expansion page = 4 + bank*4 + slot = {bank+1, slot}.
    case (map_q)
      3'd0: use_ext = 1'b0;
      3'd1: use_ext = (q == 2'd3);
      3'd2: use_ext = 1'b1;
      3'd3: begin
        if (q == 2'd1) base_page = 2'd3;
        use_ext = (q == 2'd3);
      end
      default: begin
        use_ext = (q == 2'd1);
        slot    = map_q[1:0];
      end
    endcase
    bank_p1 = {1'b0, bank_q} + {{EXP_BITS{1'b0}}, 1'b1};

    case (lo_loc_q)
      LOC_Q1:  lo_slot = 2'd1;
      LOC_Q2:  lo_slot = 2'd2;
      default: lo_slot = 2'd0;
    endcase
    lo_rom_page = (unlocked && rmr2_seen_q) ? lo_page_q : 3'd0;
    if (rom_bank_q[7])            hi_page = rom_bank_q[CART_BITS-1:0];
    else if (rom_bank_q == 8'd7)  hi_page = CART_BITS'(PAGE_AMSDOS);
    else                          hi_page = CART_BITS'(PAGE_BASIC);

    asic_d = unlocked && (lo_loc_q == LOC_ASIC) && (q == 2'd1);
    if (asic_d)                                         ram_a_d = ram_a_q;
    else if (!romen_n && !lo_dis_q && (q == lo_slot))   ram_a_d = {1'b1, PW'(lo_rom_page), A[13:0]};
    else if (!romen_n && !hi_dis_q && (q == 2'd3))      ram_a_d = {1'b1, PW'(hi_page), A[13:0]};
    else if (use_ext)                                   ram_a_d = {1'b0, PW'({bank_p1, slot}), A[13:0]};
    else                                                ram_a_d = {1'b0, PW'(base_page), A[13:0]};
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      io_wr_q     <= 1'b0;
      map_q       <= 3'd0;
      bank_q      <= '0;
      mode_q      <= 2'b01;
      lo_dis_q    <= 1'b0;
      hi_dis_q    <= 1'b0;
      lo_loc_q    <= LOC_Q0;
      lo_page_q   <= 3'd0;
      rmr2_seen_q <= 1'b0;
      rom_bank_q  <= 8'd0;
      int_reset_q <= 1'b0;
      rmr2_now_q  <= 1'b0;
      ram_a_q     <= '0;
      asic_q      <= 1'b0;
    end else begin
      io_wr_q     <= io_WR;
      map_q       <= map_d;
      bank_q      <= bank_d;
      mode_q      <= mode_d;
      lo_dis_q    <= lo_dis_d;
      hi_dis_q    <= hi_dis_d;
      lo_loc_q    <= lo_loc_d;
      lo_page_q   <= lo_page_d;
      rmr2_seen_q <= rmr2_seen_d;
      rom_bank_q  <= rom_bank_d;
      int_reset_q <= int_reset_d;
      rmr2_now_q  <= rmr2_now_d;
      ram_a_q     <= ram_a_d;
      asic_q      <= asic_d;
    end
  end

  assign ram_A     = ram_a_q;
  assign asic_sel  = asic_q;
  assign mode      = mode_q;
  assign int_reset = int_reset_q;
  assign rmr2_now  = rmr2_now_q;

endmodule

// File: tb/tb_amstrad_mmu_plus.sv
// Bench for amstrad_mmu_plus: directed scenarios plus random bus traffic, every
// cycle compared against a table-driven behavioural model of the memory map.
module tb_amstrad_mmu_plus;

  localparam int EXP_BITS = 3;
  localparam int AW       = 21;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          ram64k = 1'b0;
  logic          romen_n = 1'b1;
  logic          io_WR = 1'b0;
  logic [15:0]   A = 16'h0000;
  logic [7:0]    D = 8'h00;
  logic [AW-1:0] ram_A;
  logic          asic_sel;
  logic [1:0]    mode;
  logic          int_reset;
  logic          rmr2_now;
  logic          unlocked;

  amstrad_mmu_plus dut (
    .CLK       (CLK),
    .reset     (reset),
    .ram64k    (ram64k),
    .romen_n   (romen_n),
    .io_WR     (io_WR),
    .A         (A),
    .D         (D),
    .ram_A     (ram_A),
    .asic_sel  (asic_sel),
    .mode      (mode),
    .int_reset (int_reset),
    .rmr2_now  (rmr2_now),
    .unlocked  (unlocked)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] utab [17] = '{8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
                            8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD, 8'hEE};
  // Per RAMmap, per quarter: 0..3 = base page, 100+s = expansion slot s.
  int ram_tab [8][4] = '{'{0, 1, 2, 3}, '{0, 1, 2, 103}, '{100, 101, 102, 103}, '{0, 3, 2, 103},
                         '{0, 100, 2, 3}, '{0, 101, 2, 3}, '{0, 102, 2, 3}, '{0, 103, 2, 3}};

  int m_map, m_bank, m_mode, m_lo_loc, m_lo_page, m_rombank, m_idx;
  bit m_lo_dis, m_hi_dis, m_seen, m_unlocked, m_asic, m_prev_wr, e_int, e_rmr2;
  logic [AW-1:0] m_addr;
  logic [AW-1:0] exp_q [$];

  function automatic void model_reset();
    m_map = 0; m_bank = 0; m_mode = 1; m_lo_loc = 0; m_lo_page = 0; m_rombank = 0; m_idx = 0;
    m_lo_dis = 0; m_hi_dis = 0; m_seen = 0; m_unlocked = 0; m_asic = 0; m_addr = '0;
  endfunction

  function automatic void model_map(input logic [15:0] a, input logic rn,
                                    output bit asic, output logic [AW-1:0] addr);
    int q, lo_slot, page, cart, v;
    q = int'(a[15:14]);
    lo_slot = (m_lo_loc == 1) ? 1 : (m_lo_loc == 2) ? 2 : 0;
    asic = m_unlocked && (m_lo_loc == 3) && (q == 1);
    if (!rn && !m_lo_dis && q == lo_slot) begin
      cart = 1;
      page = (m_unlocked && m_seen) ? m_lo_page : 0;
    end else if (!rn && !m_hi_dis && q == 3) begin
      cart = 1;
      if (m_rombank >= 128)    page = m_rombank % 32;
      else if (m_rombank == 7) page = 3;
      else                     page = 1;
    end else begin
      cart = 0;
      v = ram_tab[m_map][q];
      page = (v >= 100) ? 4 + m_bank * 4 + (v - 100) : v;
    end
    addr = AW'(cart * (1 << 20) + page * (1 << 14) + int'(a[13:0]));
  endfunction

  function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
    if (a[15:8] == 8'h7F) begin
      if (d[7:6] == 2'b11) begin
        if (!ram64k) begin
          m_map  = int'(d[2:0]);
          m_bank = ((7 - int'(a[10:8])) * 8 + int'(d[5:3])) % (1 << EXP_BITS);
        end
      end else if (d[7:5] == 3'b100) begin
        m_mode = int'(d[1:0]); m_lo_dis = d[2]; m_hi_dis = d[3]; e_int = d[4];
      end else if (d[7:5] == 3'b101 && m_unlocked) begin
        m_lo_loc = int'(d[4:3]); m_lo_page = int'(d[2:0]); m_seen = 1; e_rmr2 = 1;
      end
    end else if (a[15:8] == 8'hDF) begin
      m_rombank = int'(d);
    end else if (a[15:8] == 8'hBC) begin
      if (m_idx == 16) begin
        m_unlocked = (d == 8'hEE);
        m_idx = 0;
      end else if (d == utab[m_idx]) m_idx++;
      else m_idx = (d == 8'hFF) ? 1 : 0;
    end
  endfunction

  // One clock: predict from pre-edge state and inputs, then compare after the edge.
  task automatic tick();
    bit asic;
    logic [AW-1:0] addr;
    e_int = 0; e_rmr2 = 0;
    if (reset) begin
      model_reset();
    end else begin
      model_map(A, romen_n, asic, addr);
      if (!asic) m_addr = addr;
      m_asic = asic;
      if (io_WR && !m_prev_wr) model_write(A, D);
    end
    exp_q.push_back(m_addr);
    m_prev_wr = reset ? 1'b0 : io_WR;
    @(posedge CLK);
    #1;
    check("ram_A", 32'(ram_A), 32'(exp_q.pop_front()));
    check("asic_sel", 32'(asic_sel), 32'(m_asic));
    check("mode", 32'(mode), 32'(m_mode));
    check("unlocked", 32'(unlocked), 32'(m_unlocked));
    check("int_reset", 32'(int_reset), 32'(e_int));
    check("rmr2_now", 32'(rmr2_now), 32'(e_rmr2));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1; io_WR = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    A = a; D = d; io_WR = 1'b1;
    tick();
    io_WR = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [15:0] a, input logic rn);
    A = a; romen_n = rn; io_WR = 1'b0;
    tick();
  endtask

  task automatic send_unlock(input int bad_pos, input logic [7:0] bad_val);
    for (int i = 0; i < 17; i++) wr(16'hBC00, (i == bad_pos) ? bad_val : utab[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    m_prev_wr = 1'b0;
    do_reset();
    check("rst_unlocked", 32'(unlocked), 32'd0);
    check("rst_mode", 32'(mode), 32'd1);

    rd(16'h0000, 1'b0);
    check("rom0_after_reset", 32'(ram_A), 32'h100000);

    wr(16'h7F00, 8'hC4);
    rd(16'h4000, 1'b1);
    check("mmr_c4_page4", 32'(ram_A), 32'h010000);
    wr(16'h7F00, 8'hCC);
    rd(16'h4000, 1'b1);
    check("mmr_cc_page8", 32'(ram_A), 32'h020000);

    send_unlock(-1, 8'h00);
    check("unlock_full", 32'(unlocked), 32'd1);
    wr(16'h7F00, 8'hB8);
    rd(16'h4000, 1'b1);
    check("asic_page_sel", 32'(asic_sel), 32'd1);

    send_unlock(16, 8'h00);
    check("relock_bad_final", 32'(unlocked), 32'd0);
    send_unlock(15, 8'h00);
    check("bad_cd_stays_locked", 32'(unlocked), 32'd0);
    send_unlock(-1, 8'h00);
    check("unlock_second_pass", 32'(unlocked), 32'd1);
    send_unlock(16, 8'h55);
    check("relock_non_ee", 32'(unlocked), 32'd0);

    wr(16'h7F00, 8'hA3);
    rd(16'h0000, 1'b0);
    check("locked_lo_rom_page0", 32'(ram_A), 32'h100000);

    wr(16'hDF00, 8'h85);
    rd(16'hC000, 1'b0);
    check("cart_page5", 32'(ram_A), 32'h114000);
    wr(16'hDF00, 8'h07);
    rd(16'hC000, 1'b0);
    check("amsdos_page3", 32'(ram_A), 32'h10C000);
    wr(16'hDF00, 8'h02);
    rd(16'hC000, 1'b0);
    check("basic_page1", 32'(ram_A), 32'h104000);

    // io_WR held for three cycles: a single RMR write, a single pulse
    A = 16'h7F00; D = 8'h9C; io_WR = 1'b1;
    tick();
    check("int_reset_pulse", 32'(int_reset), 32'd1);
    tick();
    check("int_reset_single", 32'(int_reset), 32'd0);
    tick();
    io_WR = 1'b0;
    tick();
    rd(16'hC000, 1'b0);
    check("hi_dis_ram", 32'(ram_A), 32'h00C000);
    check("rmr_mode0", 32'(mode), 32'd0);

    // reset in the middle of the unlock sequence forgets progress
    for (int i = 0; i < 10; i++) wr(16'hBC00, utab[i]);
    do_reset();
    for (int i = 10; i < 17; i++) wr(16'hBC00, utab[i]);
    check("reset_mid_unlock", 32'(unlocked), 32'd0);

    // random bus traffic
    for (int it = 0; it < 600; it++) begin
      case ($urandom_range(0, 11))
        0, 1: wr({8'h7F, 8'($urandom)}, {2'b11, 6'($urandom)});
        2:    wr(16'h7F00, {3'b100, 5'($urandom)});
        3:    wr(16'h7F00, {3'b101, 5'($urandom)});
        4:    wr(16'hDF00, 8'($urandom));
        5:    wr(16'hBC00, ($urandom_range(0, 3) != 0) ? utab[m_idx] : 8'($urandom));
        6:    if ($urandom_range(0, 3) == 0) send_unlock(-1, 8'h00);
              else ram64k = 1'($urandom);
        7: begin
          A = 16'h7F00; D = {2'b11, 6'($urandom)}; io_WR = 1'b1;
          repeat ($urandom_range(2, 4)) tick();
          io_WR = 1'b0;
          tick();
        end
        default: rd(16'($urandom), 1'($urandom));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/amstrad_mmu_plus.md
# amstrad_mmu_plus

Parametrised CPC/CPC-Plus memory manager: decodes Gate-Array RMR/MMR, RMR2, upper-ROM select and the ASIC unlock sequence, and produces a registered SDRAM address for every CPU access. Sits between the T80 bus and the SDRAM controller, and supports configurable RAM expansion depth and cartridge size. Beyond the base MMU it adds:
- the ASIC lock state machine;
- ASIC register-page mapping;
- 64K-bank RAM expansion beyond 128K;
- a pipelined address output.

## Interface
- EXP_BITS, default 3: log2 of expansion 64K banks (3..6; 3 = 512K).
- CART_BITS, default 5: log2 of 16K cartridge pages (3..5).
- AW, derived = 15 + max(EXP_BITS+3, CART_BITS): ram_A width.

Clocking: one clock, CLK; reset is synchronous, active-high.

- CLK  in  1  system clock
- reset  in  1  synchronous active-high reset
- ram64k  in  1  1 = MMR writes ignored, base 64K only
- romen_n  in  1  GA ROM enable, active-low
- io_WR  in  1  I/O write strobe, level
- A  in  16  CPU address
- D  in  8  CPU data out
- ram_A  out  AW  SDRAM address: bit AW-1 = cart region, then page, then A[13:0]
- asic_sel  out  1  access targets ASIC register page, not memory
- mode  out  2  GA screen mode
- int_reset  out  1  1-cycle pulse, RMR bit 4 written as 1
- rmr2_now  out  1  1-cycle pulse on accepted RMR2 write
- unlocked  out  1  ASIC unlocked

## Operation
Writes are accepted on the cycle after a rising edge of io_WR (io_WR high, previous sample low). Port decode uses A[15:8]:

- 7F (GA):
  - D[7:6]=11: MMR. Ignored when ram64k. Latch RAMmap=D[2:0] and bank={~A[10:8],D[5:3]} truncated to EXP_BITS.
  - D[7:5]=100: RMR. Latch mode=D[1:0], lo_dis=D[2], hi_dis=D[3]. D[4]=1 produces int_reset.
  - D[7:5]=101: RMR2. Accepted only when unlocked. Latch lo_loc=D[4:3] and lo_page=D[2:0]; pulse rmr2_now. When locked, the write is ignored.
- DF: ROMbank=D.
- BC (CRTC select): byte fed to the unlock FSM.

Unlock FSM, 17-byte table U = FF,00,FF,77,B3,51,A8,D4,62,39,9C,46,2B,15,8A,CD,EE, index idx 0..16:
- Byte == U[idx], idx<16: idx+1.
- idx=16: unlocked <= (byte==EE); idx <= 0. A wrong final byte re-locks.
- Mismatch at idx<16: idx <= (byte==FF) ? 1 : 0.

Page selection:
- Q = A[15:14].
- RAM page for Q=1 under RAMmap 4..7 or 0/1/3 per 6128 rules = 4 + bank*4 + slot; otherwise base page Q.
- Lower ROM:
  - Visible when romen_n=0, lo_dis=0, and Q == low slot.
  - Low slot: lo_loc 00/11 → Q0, 01 → Q1, 10 → Q2.
  - Page = lo_page when unlocked and RMR2 has been written since reset; else 0.
- Upper ROM:
  - Visible when romen_n=0, hi_dis=0, and Q=3.
  - Page = ROMbank[CART_BITS-1:0] if ROMbank[7]; else 3 if ROMbank==7; else 1.
- asic_sel = unlocked & lo_loc==11 & Q==1. It overrides RAM and ROM, and ram_A holds its previous value while asserted.
- Writes never target ROM: if io_WR=0 and the access is a memory write (mem_wr implied by the caller), the caller uses the RAM page. ram_A always reports the read view.

## Timing
Reset values:
- ram_A=0, asic_sel=0, mode=01, int_reset=0, rmr2_now=0, unlocked=0.
- idx=0, RAMmap=0, bank=0, ROMbank=0, lo_dis=0, hi_dis=0, lo_loc=00, lo_page=0.

Latency:
- ram_A and asic_sel are registered: 1 CLK after A/romen_n change.
- A register write affects ram_A 2 CLKs after the io_WR edge.
- Pulses last exactly 1 CLK, starting the cycle the write is accepted.

Edge cases:
- io_WR held high produces one write only.
- Reset asserted mid-sequence clears idx and unlocked in the same edge.
- RMR and RMR2 cannot coincide: one D byte per write.
- Bank arithmetic wraps modulo 2^EXP_BITS.

## Structure
- Package amstrad_mmu_pkg holds:
  - unlock table U;
  - port codes 7F/DF/BC;
  - function/opcode constants 11/100/101;
  - lo_loc encodings;
  - fixed page constants (BASIC=1, AMSDOS=3).
- One sub-module, asic_unlock: idx counter plus unlocked flag. Ports: CLK, reset, wr_stb, D, unlocked.

## Test plan
- Reset, then read A=0000 with romen_n=0 → 1 CLK later ram_A = {1, page 0, 0000}, unlocked=0, mode=01.
- Write MMR 7F C4, read 4000 (EXP_BITS=3) → ram_A page = 4+0*4+0 = 4. Then write 7F CC → page 8.
- Send the full U sequence to BC00 → unlocked=1 after the EE write. Write 7F B8 → rmr2_now pulse; read 4000 → asic_sel=1.
- Send U with CD replaced by 00, then the full U → unlocked stays 0 after the first pass and becomes 1 after the second. A later sequence ending in a non-EE byte → unlocked=0.
- Locked: write 7F A3 → no rmr2_now, and lower ROM stays page 0 at 0000.
- Write DF 85 then read C000 with romen_n=0 → cart page 5. DF 07 → page 3; DF 02 → page 1. Write 7F 9C → int_reset pulse, hi_dis=1, and C000 maps to RAM.
